// File: rtl/fifo_queue_ctrl.sv
`timescale 1ns/1ps
// fifo_queue_ctrl: DEPTH x WIDTH circular FIFO with edge-triggered enqueue/dequeue feeding a display scan.
// Define FIFO_OVERFLOW_FLAG_EN to turn ovf into a sticky overflow/underflow flag; otherwise ovf is tied low.
module fifo_queue_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] in,
  input  logic [PTR_W-1:0] ra,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] valid,
  output logic [PTR_W-1:0] p,
  output logic             ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             enq_r;
  logic             deq_r;
  logic             ep;
  logic             dp;
  logic             do_enq;
  logic             do_deq;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign p     = head;
  assign rd    = mem[ra];

  // When full, a simultaneous press can only dequeue; when empty, it can only enqueue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ep        = 1'b0;
    dp        = 1'b0;
    do_enq    = 1'b0;
    do_deq    = 1'b0;
    count_nxt = count;
    ep        = enq & ~enq_r;
    dp        = deq & ~deq_r;
    do_enq    = ep & ~full;
    do_deq    = dp & ~empty;
    case ({do_enq, do_deq})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      out   <= '0;
      valid <= '0;
      enq_r <= 1'b0;
      deq_r <= 1'b0;
      // NOTE: mem is reset explicitly because the display reads every address, including never-written ones.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      enq_r <= enq;
      deq_r <= deq;
      count <= count_nxt;
      // Both operations only coexist when neither full nor empty, so head != tail here.
      if (do_enq) begin
        mem[tail]   <= in;
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (do_deq) begin
        out         <= mem[head];
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
    end
  end

`ifdef FIFO_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((ep & full & ~do_deq) | (dp & empty & ~do_enq)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_queue_ctrl.sv
`timescale 1ns/1ps
// tb_fifo_queue_ctrl: directed and randomized checks of fifo_queue_ctrl against a queue-based model.
module tb_fifo_queue_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
`ifdef FIFO_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] in;
  logic [PTR_W-1:0] ra;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] p;
  logic             ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: ordered contents as a queue, plus the raw storage seen by the read port.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_mem[DEPTH];
  int               m_head;
  logic [WIDTH-1:0] m_out;
  bit               m_ovf;
  bit               m_enq_prev;
  bit               m_deq_prev;

  fifo_queue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .enq  (enq),
    .deq  (deq),
    .in   (in),
    .ra   (ra),
    .rd   (rd),
    .out  (out),
    .full (full),
    .empty(empty),
    .valid(valid),
    .p    (p),
    .ovf  (ovf)
  );

  always #10 clk = ~clk;

  function automatic logic [DEPTH-1:0] exp_valid();
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < m_q.size(); i++) v[(m_head + i) % DEPTH] = 1'b1;
    return v;
  endfunction

  task automatic model_step(input bit e, input bit d, input logic [WIDTH-1:0] din, input bit r);
    bit ep;
    bit dp;
    bit do_e;
    bit do_d;
    int n;
    if (r) begin
      m_q.delete();
      foreach (m_mem[k]) m_mem[k] = '0;
      m_head     = 0;
      m_out      = '0;
      m_ovf      = 1'b0;
      m_enq_prev = 1'b0;
      m_deq_prev = 1'b0;
    end else begin
      ep   = e && !m_enq_prev;
      dp   = d && !m_deq_prev;
      n    = m_q.size();
      do_d = dp && (n > 0);
      do_e = ep && (n < DEPTH);
      if (OVF_EN && ((ep && n == DEPTH && !do_d) || (dp && n == 0 && !do_e))) m_ovf = 1'b1;
      if (do_d) begin
        m_out  = m_q.pop_front();
        m_head = (m_head + 1) % DEPTH;
      end
      if (do_e) begin
        m_mem[(m_head + m_q.size()) % DEPTH] = din;
        m_q.push_back(din);
      end
      m_enq_prev = e;
      m_deq_prev = d;
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, settle 1 ns.
  task automatic cycle(input bit e, input bit d, input logic [WIDTH-1:0] din, input bit r = 1'b0);
    @(negedge clk);
    enq = e;
    deq = d;
    in  = din;
    rst = r;
    @(posedge clk);
    model_step(e, d, din, r);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic press_enq(input logic [WIDTH-1:0] din);
    cycle(1'b1, 1'b0, din);
    cycle(1'b0, 1'b0, din);
  endtask

  task automatic press_deq();
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (valid !== 8'h00) begin tests_failed++; $display("FAIL reset_valid: got %h expected 00", valid); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
    tests_run++; if (p !== 3'd0) begin tests_failed++; $display("FAIL reset_p: got %0d expected 0", p); end
    tests_run++; if (out !== 4'h0) begin tests_failed++; $display("FAIL reset_out: got %h expected 0", out); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      ra = PTR_W'(i);
      #1;
      tests_run++; if (rd !== 4'h0) begin tests_failed++; $display("FAIL reset_rd[%0d]: got %h expected 0", i, rd); end
    end
  endtask

  task automatic test_enqueue();
    do_reset();
    for (int i = 1; i <= 4; i++) press_enq(WIDTH'(i));
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL enq_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (p !== PTR_W'(m_head)) begin tests_failed++; $display("FAIL enq_p: got %0d expected %0d", p, m_head); end
    for (int i = 0; i < 4; i++) begin
      ra = PTR_W'(i);
      #1;
      tests_run++; if (rd !== m_mem[i]) begin tests_failed++; $display("FAIL enq_rd[%0d]: got %h expected %h", i, rd, m_mem[i]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (20) cycle(1'b1, 1'b0, 4'h5);
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL hold_valid: got %h expected %h", valid, exp_valid()); end
    cycle(1'b0, 1'b0, 4'h5);
    ra = 3'd0;
    #1;
    tests_run++; if (rd !== m_mem[0]) begin tests_failed++; $display("FAIL hold_rd0: got %h expected %h", rd, m_mem[0]); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) press_enq(WIDTH'(i));
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got %b expected 1", full); end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL fill_valid: got %h expected %h", valid, exp_valid()); end
    press_enq(4'h9);
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL ovf_enq_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL ovf_enq_flag: got %b expected %b", ovf, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      ra = PTR_W'(i);
      #1;
      tests_run++; if (rd !== m_mem[i]) begin tests_failed++; $display("FAIL ovf_enq_rd[%0d]: got %h expected %h", i, rd, m_mem[i]); end
    end
  endtask

  // Continues from the full queue left by test_fill.
  task automatic test_dequeue_wrap();
    press_deq();
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL deq1_out: got %h expected %h", out, m_out); end
    press_deq();
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL deq2_out: got %h expected %h", out, m_out); end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL deq_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (p !== PTR_W'(m_head)) begin tests_failed++; $display("FAIL deq_p: got %0d expected %0d", p, m_head); end
    press_enq(4'hA);
    press_enq(4'hB);
    for (int i = 0; i < 2; i++) begin
      ra = PTR_W'(i);
      #1;
      tests_run++; if (rd !== m_mem[i]) begin tests_failed++; $display("FAIL wrap_rd[%0d]: got %h expected %h", i, rd, m_mem[i]); end
    end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL wrap_valid: got %h expected %h", valid, exp_valid()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) press_enq(WIDTH'($urandom_range(1, 15)));
    cycle(1'b1, 1'b1, 4'hC);
    cycle(1'b0, 1'b0, 4'hC);
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL sim_mid_out: got %h expected %h", out, m_out); end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL sim_mid_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (p !== PTR_W'(m_head)) begin tests_failed++; $display("FAIL sim_mid_p: got %0d expected %0d", p, m_head); end
    ra = 3'd3;
    #1;
    tests_run++; if (rd !== m_mem[3]) begin tests_failed++; $display("FAIL sim_mid_rd3: got %h expected %h", rd, m_mem[3]); end

    do_reset();
    press_enq(4'h5);
    press_deq();
    cycle(1'b1, 1'b1, 4'h9);
    cycle(1'b0, 1'b0, 4'h9);
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL sim_empty_out: got %h expected %h", out, m_out); end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL sim_empty_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL sim_empty_ovf: got %b expected %b", ovf, m_ovf); end

    do_reset();
    for (int i = 0; i < DEPTH; i++) press_enq(WIDTH'(15 - i));
    cycle(1'b1, 1'b1, 4'h3);
    cycle(1'b0, 1'b0, 4'h3);
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL sim_full_out: got %h expected %h", out, m_out); end
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL sim_full_valid: got %h expected %h", valid, exp_valid()); end
    tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL sim_full_ovf: got %b expected %b", ovf, m_ovf); end
  endtask

  task automatic test_empty_deq();
    do_reset();
    press_enq(4'h3);
    press_deq();
    press_deq();
    tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL empty_deq_out: got %h expected %h", out, m_out); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL empty_deq_empty: got %b expected 1", empty); end
    tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL empty_deq_ovf: got %b expected %b", ovf, m_ovf); end
  endtask

  task automatic test_mid_reset();
    press_enq(4'h6);
    press_enq(4'h7);
    press_deq();
    cycle(1'b1, 1'b1, 4'hE, 1'b1);
    tests_run++; if (valid !== 8'h00) begin tests_failed++; $display("FAIL mrst_valid: got %h expected 00", valid); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL mrst_flags: got empty=%b full=%b expected 1/0", empty, full); end
    tests_run++; if (p !== 3'd0) begin tests_failed++; $display("FAIL mrst_p: got %0d expected 0", p); end
    tests_run++; if (out !== 4'h0) begin tests_failed++; $display("FAIL mrst_out: got %h expected 0", out); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL mrst_ovf: got %b expected 0", ovf); end
    ra = 3'd1;
    #1;
    tests_run++; if (rd !== 4'h0) begin tests_failed++; $display("FAIL mrst_rd1: got %h expected 0", rd); end
    // Levels still high after reset release count as fresh presses.
    cycle(1'b1, 1'b1, 4'hE);
    cycle(1'b0, 1'b0, 4'hE);
    tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL mrst_after_valid: got %h expected %h", valid, exp_valid()); end
  endtask

  task automatic test_random();
    bit e;
    bit d;
    bit r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      r = ($urandom_range(0, 199) == 0);
      cycle(e, d, WIDTH'($urandom_range(0, 15)), r);
      ra = PTR_W'($urandom_range(0, DEPTH - 1));
      #1;
      tests_run++; if (valid !== exp_valid()) begin tests_failed++; $display("FAIL rnd_valid @%0d: got %h expected %h", n, valid, exp_valid()); end
      tests_run++; if (full !== (m_q.size() == DEPTH)) begin tests_failed++; $display("FAIL rnd_full @%0d: got %b expected %b", n, full, m_q.size() == DEPTH); end
      tests_run++; if (empty !== (m_q.size() == 0)) begin tests_failed++; $display("FAIL rnd_empty @%0d: got %b expected %b", n, empty, m_q.size() == 0); end
      tests_run++; if (p !== PTR_W'(m_head)) begin tests_failed++; $display("FAIL rnd_p @%0d: got %0d expected %0d", n, p, m_head); end
      tests_run++; if (out !== m_out) begin tests_failed++; $display("FAIL rnd_out @%0d: got %h expected %h", n, out, m_out); end
      tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf @%0d: got %b expected %b", n, ovf, m_ovf); end
      tests_run++; if (rd !== m_mem[ra]) begin tests_failed++; $display("FAIL rnd_rd @%0d ra=%0d: got %h expected %h", n, ra, rd, m_mem[ra]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    enq = 1'b0;
    deq = 1'b0;
    in  = '0;
    ra  = '0;
    test_reset();
    test_enqueue();
    test_hold();
    test_fill();
    test_dequeue_wrap();
    test_simultaneous();
    test_empty_deq();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_queue_ctrl.md
Name: fifo_queue_ctrl

Overview:
- 8-entry × 4-bit circular FIFO queue with push-button style enqueue/dequeue.
- Sits directly upstream of the segment display scan unit, which it feeds with:
  - per-entry valid bits;
  - the head pointer;
  - a combinational read port (display supplies the address, queue returns the entry data).
- Also exposes the last dequeued value and full/empty status for LEDs.

Parameters:
- WIDTH, 4, data bits per entry.
- DEPTH, 8, number of entries; must be a power of two.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- enq  input  1  enqueue request level; already debounced upstream.
- deq  input  1  dequeue request level; already debounced upstream.
- in  input  WIDTH  data to enqueue.
- ra  input  PTR_W  display read address.
- rd  output  WIDTH  combinational read data, equal to mem[ra].
- out  output  WIDTH  registered last-dequeued value.
- full  output  1  high when all DEPTH entries are valid.
- empty  output  1  high when no entry is valid.
- valid  output  DEPTH  bit i high when mem[i] holds a queued entry.
- p  output  PTR_W  head pointer, i.e. index of the oldest entry.
- ovf  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at a rising edge):
  - head, tail and count go to 0; valid and out go to 0; all mem entries go to 0.
  - enq_r and deq_r go to 0; ovf goes to 0.
  - Reset mid-operation discards all queued data in that same cycle.
- Edge detection:
  - enq_r and deq_r are registered copies of enq and deq.
  - ep = enq & ~enq_r; dp = deq & ~deq_r.
  - Holding a level high produces exactly one operation. The next operation needs a release, then a re-press.
- Latency: the operation commits at the first rising edge where the level is sampled 1 with the registered copy at 0. Outputs reflect it immediately after that edge.
- Enqueue (ep=1 and not full):
  - mem[tail] <= in; valid[tail] <= 1.
  - tail <= tail+1, wrapping mod DEPTH; count += 1.
- Dequeue (dp=1 and not empty):
  - out <= mem[head]; valid[head] <= 0.
  - head <= head+1, wrapping mod DEPTH; count -= 1.
  - mem content is not cleared.
- Simultaneous ep and dp:
  - Queue empty: only the enqueue is performed.
  - Queue full: only the dequeue is performed.
  - Otherwise: both are performed, out gets the old head, and count is unchanged.
- Illegal operations:
  - Enqueue while full is ignored; mem, tail and valid are unchanged.
  - Dequeue while empty is ignored; out holds its previous value.
- Status flags:
  - full = (count == DEPTH); empty = (count == 0).
  - count is PTR_W+1 bits and never exceeds DEPTH.
- Outputs:
  - p = head.
  - valid bits are always contiguous from head, modulo DEPTH.
  - rd is purely combinational from mem and ra, with no clock latency, so the display scan can read on any cycle.
- Pointer wrap: 7+1 = 0 for both head and tail.

Optional Feature:
- Macro: FIFO_OVERFLOW_FLAG_EN.
- Defined:
  - ovf becomes a sticky register.
  - It is set at the edge where an ep occurs while full without a simultaneous legal dequeue.
  - It is also set where a dp occurs while empty without a simultaneous enqueue.
  - It is cleared only by rst.
- Undefined: ovf is tied to 0 and no logic is generated. The port list is identical in both builds.

Test Plan:
- Reset then idle → valid=8'h00, empty=1, full=0, p=0, out=0, rd=0 for every ra.
- Four separate enq presses with in=1,2,3,4 → valid=8'h0F, p=0; rd reads 1,2,3,4 at ra=0..3.
- Hold enq=1 for 20 cycles with in=5 → exactly one entry is added.
- Eight enqueues with in=0..7 → full=1, valid=8'hFF.
  - A ninth enqueue with in=9 is ignored: mem unchanged, tail=0.
  - With FIFO_OVERFLOW_FLAG_EN defined, ovf=1.
- Starting from the full state, dequeue twice → out=0 then out=1; valid=8'hFC, p=2.
  - Then two enqueues with in=A,B → mem[0]=A, mem[1]=B, valid=8'hFF (wrap-around check).
- Queue holding 3 entries, ep and dp at the same edge → out=old head, count stays 3, p and tail each advance by 1.
  - Same stimulus with an empty queue → enqueue only, out unchanged, valid shows 1 bit set.
- Dequeue while empty → out holds its value, ovf=1 only if the macro is defined.
  - Assert rst mid-stream → all flags and pointers return to reset values on the next edge.
